// File: rtl/mem_arb_pkg.sv
// Shared types and port identifiers for the unified memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side handshake and memory-side bus of the arbiter.
// The master modport is the environment (core, loader, memory); slave is the arbiter.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          req1;
  logic          we0;
  logic          we1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          lock1;
  logic          gnt0;
  logic          gnt1;
  logic          rvalid0;
  logic          rvalid1;
  logic [DW-1:0] rdata;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rd,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_addr, mem_wd
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, lock1, mem_rd,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_we, mem_addr, mem_wd
  );
endinterface

// File: rtl/arb_rr_pick.sv
// Combinational 2-way round-robin picker; lock_ok forces the DMA port on a conflict.
module arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  input  logic lock_ok,
  output logic winner,
  output logic valid
);

  // Lone requester wins; on conflict the lock or the port that did not go last wins.
  always_comb begin
    winner = PORT_CPU;
    valid  = 1'b0;
    if (req0 && req1) begin
      valid = 1'b1;
      if (lock_ok) begin
        winner = PORT_DMA;
      end else begin
        winner = ~last_owner;
      end
    end else if (req0) begin
      valid  = 1'b1;
      winner = PORT_CPU;
    end else if (req1) begin
      valid  = 1'b1;
      winner = PORT_DMA;
    end else begin
      valid  = 1'b0;
      winner = PORT_CPU;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between the core (port 0) and the DMA/debug loader (port 1).
// Optional MEM_ARB_PERF_EN adds grant and conflict counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic clk,
  input  logic reset,
  mem_port_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] perf_gnt0,
  output logic [31:0] perf_gnt1,
  output logic [31:0] perf_conflict
`endif
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  arb_state_t    state_r, state_nxt_s;
  logic          owner_r, last_owner_r;
  logic [CW-1:0] lock_cnt_r, lock_cnt_nxt_s;
  logic          pick_winner_s, pick_valid_s, lock_ok_s;
  logic          sel_we_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;
  logic          gnt0_r, gnt1_r, rvalid0_r, rvalid1_r, mem_we_r;
  logic [DW-1:0] rdata_r, mem_wd_r;
  logic [AW-1:0] mem_addr_r;

  assign lock_ok_s = (last_owner_r == PORT_DMA) && bus.lock1 && bus.req1 &&
                     (lock_cnt_r < CW'(LOCK_MAX));

  arb_rr_pick u_pick (
    .req0       (bus.req0),
    .req1       (bus.req1),
    .last_owner (last_owner_r),
    .lock_ok    (lock_ok_s),
    .winner     (pick_winner_s),
    .valid      (pick_valid_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ARB_IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next state, winner's request mux and lock counter update.
  always_comb begin
    state_nxt_s    = state_r;
    sel_we_s       = bus.we0;
    sel_addr_s     = bus.addr0;
    sel_wdata_s    = bus.wdata0;
    lock_cnt_nxt_s = lock_cnt_r;
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) state_nxt_s = ARB_ACCESS;
        else              state_nxt_s = ARB_IDLE;
      end
      ARB_ACCESS: state_nxt_s = ARB_IDLE;
      default:    state_nxt_s = ARB_IDLE;
    endcase
    if (pick_winner_s == PORT_DMA) begin
      sel_we_s    = bus.we1;
      sel_addr_s  = bus.addr1;
      sel_wdata_s = bus.wdata1;
    end else begin
      sel_we_s    = bus.we0;
      sel_addr_s  = bus.addr0;
      sel_wdata_s = bus.wdata0;
    end
    // Every DMA win against a waiting core consumes lock budget.
    if (pick_winner_s == PORT_CPU || !bus.lock1) begin
      lock_cnt_nxt_s = {CW{1'b0}};
    end else if (bus.req0 && (lock_cnt_r < CW'(LOCK_MAX))) begin
      lock_cnt_nxt_s = lock_cnt_r + CW'(1);
    end else begin
      lock_cnt_nxt_s = lock_cnt_r;
    end
  end

  // Capture the winner on IDLE->ACCESS; return read data on ACCESS->IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_r      <= PORT_CPU;
      last_owner_r <= PORT_DMA;
      lock_cnt_r   <= {CW{1'b0}};
      gnt0_r       <= 1'b0;
      gnt1_r       <= 1'b0;
      rvalid0_r    <= 1'b0;
      rvalid1_r    <= 1'b0;
      rdata_r      <= {DW{1'b0}};
      mem_we_r     <= 1'b0;
      mem_addr_r   <= {AW{1'b0}};
      mem_wd_r     <= {DW{1'b0}};
    end else begin
      gnt0_r    <= 1'b0;
      gnt1_r    <= 1'b0;
      rvalid0_r <= 1'b0;
      rvalid1_r <= 1'b0;
      mem_we_r  <= 1'b0;
      if (state_r == ARB_IDLE && pick_valid_s) begin
        owner_r      <= pick_winner_s;
        last_owner_r <= pick_winner_s;
        lock_cnt_r   <= lock_cnt_nxt_s;
        gnt0_r       <= (pick_winner_s == PORT_CPU);
        gnt1_r       <= (pick_winner_s == PORT_DMA);
        mem_we_r     <= sel_we_s;
        mem_addr_r   <= sel_addr_s;
        mem_wd_r     <= sel_wdata_s;
      end else if (state_r == ARB_ACCESS && !mem_we_r) begin
        rdata_r   <= bus.mem_rd;
        rvalid0_r <= (owner_r == PORT_CPU);
        rvalid1_r <= (owner_r == PORT_DMA);
      end
    end
  end

  assign bus.gnt0     = gnt0_r;
  assign bus.gnt1     = gnt1_r;
  assign bus.rvalid0  = rvalid0_r;
  assign bus.rvalid1  = rvalid1_r;
  assign bus.rdata    = rdata_r;
  assign bus.mem_we   = mem_we_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_wd   = mem_wd_r;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_gnt0_r, perf_gnt1_r, perf_conflict_r;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_gnt0_r     <= 32'd0;
      perf_gnt1_r     <= 32'd0;
      perf_conflict_r <= 32'd0;
    end else begin
      if (gnt0_r) perf_gnt0_r <= perf_gnt0_r + 32'd1;
      if (gnt1_r) perf_gnt1_r <= perf_gnt1_r + 32'd1;
      if (state_r == ARB_IDLE && bus.req0 && bus.req1 && pick_valid_s)
        perf_conflict_r <= perf_conflict_r + 32'd1;
    end
  end

  assign perf_gnt0     = perf_gnt0_r;
  assign perf_gnt1     = perf_gnt1_r;
  assign perf_conflict = perf_conflict_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: read results are queued at grant and checked at rvalid.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  logic [31:0] mem [0:255];
  logic [32:0] sb_q[$];
  logic [32:0] mon_exp;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_gnt0, perf_gnt1, perf_conflict;
`endif

  mem_port_arbiter_if #(.AW(32), .DW(32)) bif ();

  mem_port_arbiter #(.AW(32), .DW(32), .LOCK_MAX(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_gnt0     (perf_gnt0),
    .perf_gnt1     (perf_gnt1),
    .perf_conflict (perf_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bif.mem_rd = mem[bif.mem_addr[9:2]];

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory model: preload, then commit writes on the clock edge.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h5A00_0000 | 32'(i);
    mem[4]  = 32'hDEAD_BEEF;
    mem[8]  = 32'h0000_0000;
    mem[9]  = 32'hCAFE_0009;
    mem[12] = 32'hA5A5_A5A5;
    forever begin
      @(posedge clk);
      if (bif.mem_we) mem[bif.mem_addr[9:2]] <= bif.mem_wd;
    end
  end

  // Read-data monitor pops the scoreboard on every rvalid.
  always @(negedge clk) begin
    if (bif.rvalid0 || bif.rvalid1) begin
      chk_eq("rv_both", 32'(bif.rvalid0 & bif.rvalid1), 32'd0);
      if (sb_q.size() == 0) begin
        chk_eq("rv_unexpected", 32'(bif.rvalid0 | bif.rvalid1), 32'd0);
      end else begin
        mon_exp = sb_q.pop_front();
        chk_eq("rv_port", 32'(bif.rvalid1), 32'(mon_exp[32]));
        chk_eq("rdata", bif.rdata, mon_exp[31:0]);
      end
    end
  end

  task automatic expect_grant(input string tag, input logic port);
    chk_eq({tag, "_gnt0"}, 32'(bif.gnt0), 32'(port == PORT_CPU));
    chk_eq({tag, "_gnt1"}, 32'(bif.gnt1), 32'(port == PORT_DMA));
  endtask

  task automatic check_outputs_zero(input string tag);
    chk_eq({tag, "_gnt"}, {30'd0, bif.gnt1, bif.gnt0}, 32'd0);
    chk_eq({tag, "_rvalid"}, {30'd0, bif.rvalid1, bif.rvalid0}, 32'd0);
    chk_eq({tag, "_rdata"}, bif.rdata, 32'd0);
    chk_eq({tag, "_mem_we"}, 32'(bif.mem_we), 32'd0);
    chk_eq({tag, "_mem_addr"}, bif.mem_addr, 32'd0);
    chk_eq({tag, "_mem_wd"}, bif.mem_wd, 32'd0);
  endtask

  // Conflict run: both ports read continuously, grants compared against an expected sequence.
  task automatic run_conflict(input string tag, input int n, input logic [15:0] seq);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      expect_grant(tag, seq[k]);
      if (seq[k] == PORT_DMA) sb_q.push_back({1'b1, 32'hCAFE_0009});
      else                    sb_q.push_back({1'b0, 32'hDEAD_BEEF});
      @(negedge clk);
      chk_eq({tag, "_idle_gnt"}, {30'd0, bif.gnt1, bif.gnt0}, 32'd0);
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    reset      = 1'b1;
    bif.req0   = 1'b0;
    bif.req1   = 1'b0;
    bif.we0    = 1'b0;
    bif.we1    = 1'b0;
    bif.addr0  = 32'd0;
    bif.addr1  = 32'd0;
    bif.wdata0 = 32'd0;
    bif.wdata1 = 32'd0;
    bif.lock1  = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
`ifdef MEM_ARB_PERF_EN
    chk_eq("perf_reset", perf_gnt0 | perf_gnt1 | perf_conflict, 32'd0);
`endif
    reset = 1'b0;

    // Single read from port 0.
    bif.addr0 = 32'h10;
    bif.req0  = 1'b1;
    @(negedge clk);
    expect_grant("t1", PORT_CPU);
    chk_eq("t1_mem_addr", bif.mem_addr, 32'h10);
    chk_eq("t1_mem_we", 32'(bif.mem_we), 32'd0);
    sb_q.push_back({1'b0, 32'hDEAD_BEEF});
    bif.req0 = 1'b0;
    @(negedge clk);
    chk_eq("t1_idle_gnt", {30'd0, bif.gnt1, bif.gnt0}, 32'd0);

    // Single write from port 1.
    bif.addr1  = 32'h20;
    bif.wdata1 = 32'h1234_5678;
    bif.we1    = 1'b1;
    bif.req1   = 1'b1;
    @(negedge clk);
    expect_grant("t2", PORT_DMA);
    chk_eq("t2_mem_we", 32'(bif.mem_we), 32'd1);
    chk_eq("t2_mem_addr", bif.mem_addr, 32'h20);
    chk_eq("t2_mem_wd", bif.mem_wd, 32'h1234_5678);
    bif.req1 = 1'b0;
    bif.we1  = 1'b0;
    @(negedge clk);
    chk_eq("t2_mem8", mem[8], 32'h1234_5678);
    chk_eq("t2_mem_we_low", 32'(bif.mem_we), 32'd0);
    @(negedge clk);

    // Conflict from reset: strict alternation starting with port 0.
    reset     = 1'b1;
    bif.addr0 = 32'h10;
    bif.addr1 = 32'h24;
    bif.req0  = 1'b1;
    bif.req1  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_conflict("t3", 10, 16'b0000_0010_1010_1010);
`ifdef MEM_ARB_PERF_EN
    chk_eq("perf_gnt0", perf_gnt0, 32'd5);
    chk_eq("perf_gnt1", perf_gnt1, 32'd5);
    chk_eq("perf_conflict", perf_conflict, 32'd10);
`endif
    bif.req0 = 1'b0;
    bif.req1 = 1'b0;
    @(negedge clk);

    // Lock from reset: 8 locked DMA grants, one core grant, then DMA again.
    reset     = 1'b1;
    bif.req0  = 1'b1;
    bif.req1  = 1'b1;
    bif.lock1 = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    run_conflict("t4", 11, 16'b0000_0110_1111_1111);
    bif.req0  = 1'b0;
    bif.req1  = 1'b0;
    bif.lock1 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Reset while a write to 0x30 is in ACCESS.
    bif.addr0  = 32'h30;
    bif.wdata0 = 32'hFFFF_FFFF;
    bif.we0    = 1'b1;
    bif.req0   = 1'b1;
    @(negedge clk);
    chk_eq("t5_mem_we_pre", 32'(bif.mem_we), 32'd1);
    #1 reset = 1'b1;
    #1 check_outputs_zero("t5_async");
    bif.req0 = 1'b0;
    bif.we0  = 1'b0;
    @(negedge clk);
    chk_eq("t5_mem12", mem[12], 32'hA5A5_A5A5);
    check_outputs_zero("t5_hold");
    reset = 1'b0;

    // Recovery: lone port-1 read right after reset.
    bif.addr1 = 32'h24;
    bif.req1  = 1'b1;
    @(negedge clk);
    expect_grant("t6", PORT_DMA);
    sb_q.push_back({1'b1, 32'hCAFE_0009});
    bif.req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk_eq("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
